regfile_port_arbiter: RTL

Controller that shares the register file's single enable-gated access port between two requesters: the core pipeline (port C) and a debug/loader host (port D). It arbitrates between the two requesters with round-robin and latches the winner's command. It then pulses the register file enable for exactly one clock, waits for the done flag and returns both read words to the winner with a one-cycle acknowledge. It sits between the core/debug logic and the register file; neither requester drives the register file directly.

---
 rtl/regfile_port_arbiter_if.sv | 42 ++++
 rtl/regfile_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle between the two requesters (C = core, D = debug/loader), the
// shared register-file access port and the regfile_port_arbiter controller.
interface regfile_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              c_req, c_we, c_ack, c_err;
  logic [ADDR_W-1:0] c_ra1, c_ra2, c_wa;
  logic [DATA_W-1:0] c_wd, c_rd1, c_rd2;

  logic              d_req, d_we, d_ack, d_err;
  logic [ADDR_W-1:0] d_ra1, d_ra2, d_wa;
  logic [DATA_W-1:0] d_wd, d_rd1, d_rd2;

  logic              busy;

  logic              rf_en, rf_reg_write, rf_done;
  logic [ADDR_W-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [DATA_W-1:0] rf_write_data, rf_read_data1, rf_read_data2;

  // Arbiter side.
  modport slave (
    input  c_req, c_we, c_ra1, c_ra2, c_wa, c_wd,
    input  d_req, d_we, d_ra1, d_ra2, d_wa, d_wd,
    input  rf_read_data1, rf_read_data2, rf_done,
    output c_ack, c_rd1, c_rd2, c_err,
    output d_ack, d_rd1, d_rd2, d_err,
    output busy,
    output rf_en, rf_reg_write, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data
  );

  // Requester / register-file side.
  modport master (
    output c_req, c_we, c_ra1, c_ra2, c_wa, c_wd,
    output d_req, d_we, d_ra1, d_ra2, d_wa, d_wd,
    output rf_read_data1, rf_read_data2, rf_done,
    input  c_ack, c_rd1, c_rd2, c_err,
    input  d_ack, d_rd1, d_rd2, d_err,
    input  busy,
    input  rf_en, rf_reg_write, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one enable-gated register-file port between C and D.
// Optional WAIT-state timeout enabled by defining RF_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | sample c_req/d_req, grant and latch the winner's command
// S_ISSUE | rf_en high for this single cycle
// S_WAIT  | hold rf_* fields, wait for rf_done (or timeout)
// S_RESP  | winner's ack high for one cycle
module regfile_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("regfile_port_arbiter: TIMEOUT must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;   // 1 = D was granted last
  logic              win_q, win_d;     // 1 = D owns the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              rf_en_q, rf_en_d;
  logic              busy_q, busy_d;
  logic              c_ack_q, c_ack_d, d_ack_q, d_ack_d;
  logic              c_err_q, c_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] c_rd1_q, c_rd1_d, c_rd2_q, c_rd2_d;
  logic [DATA_W-1:0] d_rd1_q, d_rd1_d, d_rd2_q, d_rd2_d;
  logic              timed_out;
  logic              grant_d;

`ifdef RF_ARB_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Down-counter loaded on WAIT entry; terminal count ends the TIMEOUT-th WAIT cycle.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == S_ISSUE) begin
      tmr_d = TMR_LOAD;
    end else if (state_q == S_WAIT && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  assign timed_out = (state_q == S_WAIT) && !bus.rf_done && (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    rf_en_d = 1'b0;
    c_ack_d = 1'b0;
    d_ack_d = 1'b0;
    c_err_d = 1'b0;
    d_err_d = 1'b0;
    c_rd1_d = c_rd1_q;
    c_rd2_d = c_rd2_q;
    d_rd1_d = d_rd1_q;
    d_rd2_d = d_rd2_q;
    grant_d = (bus.c_req && bus.d_req) ? ~last_q : bus.d_req;

    case (state_q)
      S_IDLE: begin
        if (bus.c_req || bus.d_req) begin
          win_d   = grant_d;
          last_d  = grant_d;
          we_d    = grant_d ? bus.d_we  : bus.c_we;
          ra1_d   = grant_d ? bus.d_ra1 : bus.c_ra1;
          ra2_d   = grant_d ? bus.d_ra2 : bus.c_ra2;
          wa_d    = grant_d ? bus.d_wa  : bus.c_wa;
          wd_d    = grant_d ? bus.d_wd  : bus.c_wd;
          rf_en_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // rf_done may be left high from an earlier access; only WAIT looks at it.
        if (bus.rf_done || timed_out) begin
          state_d = S_RESP;
          if (win_q) begin
            d_ack_d = 1'b1;
            d_err_d = timed_out;
            d_rd1_d = timed_out ? '0 : bus.rf_read_data1;
            d_rd2_d = timed_out ? '0 : bus.rf_read_data2;
          end else begin
            c_ack_d = 1'b1;
            c_err_d = timed_out;
            c_rd1_d = timed_out ? '0 : bus.rf_read_data1;
            c_rd2_d = timed_out ? '0 : bus.rf_read_data2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      rf_en_q <= 1'b0;
      busy_q  <= 1'b0;
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      c_err_q <= 1'b0;
      d_err_q <= 1'b0;
      c_rd1_q <= '0;
      c_rd2_q <= '0;
      d_rd1_q <= '0;
      d_rd2_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      rf_en_q <= rf_en_d;
      busy_q  <= busy_d;
      c_ack_q <= c_ack_d;
      d_ack_q <= d_ack_d;
      c_err_q <= c_err_d;
      d_err_q <= d_err_d;
      c_rd1_q <= c_rd1_d;
      c_rd2_q <= c_rd2_d;
      d_rd1_q <= d_rd1_d;
      d_rd2_q <= d_rd2_d;
    end
  end

  assign bus.rf_en         = rf_en_q;
  assign bus.rf_reg_write  = we_q;
  assign bus.rf_read_reg1  = ra1_q;
  assign bus.rf_read_reg2  = ra2_q;
  assign bus.rf_write_reg  = wa_q;
  assign bus.rf_write_data = wd_q;
  assign bus.busy          = busy_q;
  assign bus.c_ack         = c_ack_q;
  assign bus.d_ack         = d_ack_q;
  assign bus.c_err         = c_err_q;
  assign bus.d_err         = d_err_q;
  assign bus.c_rd1         = c_rd1_q;
  assign bus.c_rd2         = c_rd2_q;
  assign bus.d_rd1         = d_rd1_q;
  assign bus.d_rd2         = d_rd2_q;

endmodule
